// File: rtl/junction_pkg.sv
// Shared types and constants for the junction traffic-light controller.
// Phase codes are visible on the debug port, so their values are fixed.
package junction_pkg;

  typedef enum logic [3:0] {
    ALLRED_A = 4'd0,
    NS_RA    = 4'd1,
    NS_G     = 4'd2,
    NS_A     = 4'd3,
    ALLRED_B = 4'd4,
    EW_RA    = 4'd5,
    EW_G     = 4'd6,
    EW_A     = 4'd7,
    PED      = 4'd8
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // Lamp encoding is {green, amber, red}.
  localparam logic [2:0] LAMP_RED   = 3'b001;
  localparam logic [2:0] LAMP_RA    = 3'b011;
  localparam logic [2:0] LAMP_GREEN = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;

  localparam int DEF_RA_TICKS     = 2;
  localparam int DEF_GREEN_TICKS  = 8;
  localparam int DEF_AMBER_TICKS  = 3;
  localparam int DEF_ALLRED_TICKS = 1;
  localparam int DEF_PED_TICKS    = 5;
  localparam int DEF_CNT_W        = 8;

  // Lamp for one head given its own red+amber / green / amber phases.
  function automatic logic [2:0] head_lamp(phase_e ph, phase_e ra, phase_e g, phase_e a);
    logic [2:0] l;
    l = LAMP_RED;
    if (ph == ra)     l = LAMP_RA;
    else if (ph == g) l = LAMP_GREEN;
    else if (ph == a) l = LAMP_AMBER;
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; zero flags the last tick of a phase.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/junction_controller.sv
// Two-head junction sequencer with a pedestrian phase slotted into all-red gaps.
// All outputs decode from registered state, so lamps change only on clock edges.
module junction_controller import junction_pkg::*; #(
  parameter int RA_TICKS     = DEF_RA_TICKS,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int AMBER_TICKS  = DEF_AMBER_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int PED_TICKS    = DEF_PED_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_amber,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_amber,
  output logic       ew_green,
  output logic       ped_walk,
  output logic       ped_wait,
  output logic [3:0] phase
);

  phase_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic             wait_q, wait_d;
  logic             tmr_zero, advance, load;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       ns_lamp, ew_lamp;

  function automatic logic [CNT_W-1:0] phase_len_m1(phase_e ph);
    logic [CNT_W-1:0] v;
    case (ph)
      NS_RA, EW_RA: v = CNT_W'(RA_TICKS - 1);
      NS_G,  EW_G:  v = CNT_W'(GREEN_TICKS - 1);
      NS_A,  EW_A:  v = CNT_W'(AMBER_TICKS - 1);
      PED:          v = CNT_W'(PED_TICKS - 1);
      default:      v = CNT_W'(ALLRED_TICKS - 1);
    endcase
    return v;
  endfunction

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(ALLRED_TICKS - 1))
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .en      (enable),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    advance = enable && tmr_zero;
    case (state_q)
      ALLRED_A: if (advance) state_d = wait_q ? PED : NS_RA;
      NS_RA:    if (advance) state_d = NS_G;
      NS_G:     if (advance) state_d = NS_A;
      NS_A:     if (advance) state_d = ALLRED_B;
      ALLRED_B: if (advance) state_d = wait_q ? PED : EW_RA;
      EW_RA:    if (advance) state_d = EW_G;
      EW_G:     if (advance) state_d = EW_A;
      EW_A:     if (advance) state_d = ALLRED_A;
      PED:      if (advance) state_d = (dir_q == DIR_NS) ? NS_RA : EW_RA;
      // Corrupted codes fall back to all-red regardless of enable.
      default:  state_d = ALLRED_A;
    endcase
    // Every transition changes state, so a change is exactly a phase entry.
    load     = (state_d != state_q);
    load_val = phase_len_m1(state_d);
  end

  always_comb begin
    dir_d = dir_q;
    if (state_q == ALLRED_A)      dir_d = DIR_NS;
    else if (state_q == ALLRED_B) dir_d = DIR_EW;
  end

  // Entry into PED clears the latch and wins over a same-cycle press.
  always_comb begin
    wait_d = wait_q | (ped_req && (state_q != PED));
    if (state_d == PED && state_q != PED) wait_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLRED_A;
      dir_q   <= DIR_NS;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wait_q  <= wait_d;
    end
  end

  assign ns_lamp = head_lamp(state_q, NS_RA, NS_G, NS_A);
  assign ew_lamp = head_lamp(state_q, EW_RA, EW_G, EW_A);

  assign {ns_green, ns_amber, ns_red} = ns_lamp;
  assign {ew_green, ew_amber, ew_red} = ew_lamp;
  assign ped_walk = (state_q == PED);
  assign ped_wait = wait_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_junction_controller.sv
// Bench for junction_controller: constant vector table, directed corner cases,
// and a randomized run against a tick-counting reference model.
module tb_junction_controller;

  localparam int RA = 2, GR = 8, AM = 3, AR = 1, PT = 5;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ped_req = 1'b0;
  logic       ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green;
  logic       ped_walk, ped_wait;
  logic [3:0] phase;

  junction_controller #(
    .RA_TICKS(RA), .GREEN_TICKS(GR), .AMBER_TICKS(AM),
    .ALLRED_TICKS(AR), .PED_TICKS(PT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req),
    .ns_red(ns_red), .ns_amber(ns_amber), .ns_green(ns_green),
    .ew_red(ew_red), .ew_amber(ew_amber), .ew_green(ew_green),
    .ped_walk(ped_walk), .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index, enabled ticks left in it, latched request,
  // and the vehicular phase a pedestrian window returns to.
  int m_ph, m_left, m_ret;
  bit m_wait;

  function automatic int dur(int ph);
    case (ph)
      1, 5:    return RA;
      2, 6:    return GR;
      3, 7:    return AM;
      8:       return PT;
      default: return AR;
    endcase
  endfunction

  function automatic logic [2:0] head(int ph, bit ew);
    int b;
    b = ew ? 5 : 1;
    if (ph == b)     return 3'b011;
    if (ph == b + 1) return 3'b100;
    if (ph == b + 2) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_left = AR; m_wait = 1'b0; m_ret = 1;
  endfunction

  function automatic void model_step(bit en, bit req);
    int  old;
    bit  enter_ped;
    old = m_ph;
    enter_ped = 1'b0;
    if (en) begin
      if (m_left > 1) m_left--;
      else begin
        if ((old == 0 || old == 4) && m_wait) begin
          m_ret = (old == 0) ? 1 : 5;
          m_ph = 8;
          enter_ped = 1'b1;
        end else if (old == 8) m_ph = m_ret;
        else m_ph = (old + 1) % 8;
        m_left = dur(m_ph);
      end
    end
    if (enter_ped) m_wait = 1'b0;
    else if (req && old != 8) m_wait = 1'b1;
  endfunction

  function automatic bit legal_next(logic [2:0] a, logic [2:0] b);
    return (a == b) || (a == 3'b001 && b == 3'b011) || (a == 3'b011 && b == 3'b100) ||
           (a == 3'b100 && b == 3'b010) || (a == 3'b010 && b == 3'b001);
  endfunction

  function automatic logic [11:0] dut_vec();
    return {phase, ns_green, ns_amber, ns_red, ew_green, ew_amber, ew_red, ped_walk, ped_wait};
  endfunction

  function automatic logic [11:0] model_vec();
    return {4'(m_ph), head(m_ph, 1'b0), head(m_ph, 1'b1), 1'(m_ph == 8), m_wait};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit en, input bit req);
    enable = en; ped_req = req;
    model_step(en, req);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         en, req;
    int         ph;
    logic [2:0] ns, ew;
    bit         walk, wt;
  } vec_t;

  function automatic vec_t mk(bit en, bit req, int ph, logic [2:0] ns, logic [2:0] ew, bit walk, bit wt);
    vec_t v;
    v.en = en; v.req = req; v.ph = ph; v.ns = ns; v.ew = ew; v.walk = walk; v.wt = wt;
    return v;
  endfunction

  vec_t tv[20];

  initial begin
    logic [2:0] pns, pew;
    int cnt, t_first, t_second, ped_cnt;
    bit saw_ns_g, saw_ew_g;

    for (int i = 0; i < 20; i++) begin
      if (i < 2)       tv[i] = mk(1, 0, 1, 3'b011, 3'b001, 0, 0);
      else if (i < 4)  tv[i] = mk(1, 0, 2, 3'b100, 3'b001, 0, 0);
      else if (i == 4) tv[i] = mk(1, 1, 2, 3'b100, 3'b001, 0, 1);
      else if (i < 10) tv[i] = mk(1, 0, 2, 3'b100, 3'b001, 0, 1);
      else if (i < 13) tv[i] = mk(1, 0, 3, 3'b010, 3'b001, 0, 1);
      else if (i < 14) tv[i] = mk(1, 0, 4, 3'b001, 3'b001, 0, 1);
      else if (i < 19) tv[i] = mk(1, 0, 8, 3'b001, 3'b001, 1, 0);
      else             tv[i] = mk(1, 0, 5, 3'b001, 3'b011, 0, 0);
    end

    // Reset state
    rst_n = 1'b0;
    #23;
    check("rst_phase", phase, 0);
    check("rst_ns", {ns_green, ns_amber, ns_red}, 3'b001);
    check("rst_ew", {ew_green, ew_amber, ew_red}, 3'b001);
    check("rst_walk", ped_walk, 0);
    check("rst_wait", ped_wait, 0);

    // Vector table: plain cycle start, a press during NS green, pedestrian window
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enable = tv[i].en; ped_req = tv[i].req;
      @(posedge clk);
      #1;
      check($sformatf("tv%0d_phase", i), phase, tv[i].ph);
      check($sformatf("tv%0d_ns", i), {ns_green, ns_amber, ns_red}, tv[i].ns);
      check($sformatf("tv%0d_ew", i), {ew_green, ew_amber, ew_red}, tv[i].ew);
      check($sformatf("tv%0d_walk", i), ped_walk, tv[i].walk);
      check($sformatf("tv%0d_wait", i), ped_wait, tv[i].wt);
    end

    // Full cycles with no pedestrians; NS red+amber recurs every 28 cycles
    do_reset();
    t_first = -1; t_second = -1;
    pns = 3'b001;
    for (int c = 1; c <= 60; c++) begin
      step(1'b1, 1'b0);
      check("cycle_model", dut_vec(), model_vec());
      if (pns != 3'b011 && ns_amber && ns_red) begin
        if (t_first < 0) t_first = c; else if (t_second < 0) t_second = c;
      end
      pns = {ns_green, ns_amber, ns_red};
    end
    check("period", t_second - t_first, 28);
    check("first_ra_edge", t_first, 1);

    // Freeze mid NS green for 10 cycles; remaining green is preserved
    do_reset();
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
    check("frz_start_phase", phase, 2);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0);
      check("frz_phase", phase, 2);
      check("frz_ns", {ns_green, ns_amber, ns_red}, 3'b100);
    end
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0);
      if (phase != 4'd2) break;
      cnt++;
    end
    check("frz_remaining", cnt, 4);
    check("frz_then_amber", phase, 3);

    // Asynchronous reset between edges during EW green
    do_reset();
    for (int c = 0; c < 18; c++) step(1'b1, 1'b0);
    check("ar_pre_phase", phase, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_phase", phase, 0);
    check("ar_ns", {ns_green, ns_amber, ns_red}, 3'b001);
    check("ar_ew", {ew_green, ew_amber, ew_red}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0);
    check("ar_restart_ns", phase, 1);

    // Button held down: pedestrian window at every all-red, both heads still served
    do_reset();
    saw_ns_g = 1'b0; saw_ew_g = 1'b0; ped_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1, 1'b1);
      check("hold_model", dut_vec(), model_vec());
      check("hold_walk_red", ped_walk && !(ns_red && ew_red), 0);
      if (ns_green) saw_ns_g = 1'b1;
      if (ew_green) saw_ew_g = 1'b1;
      if (ped_walk && phase == 4'd8 && m_left == PT) ped_cnt++;
    end
    check("hold_ns_green", saw_ns_g, 1);
    check("hold_ew_green", saw_ew_g, 1);
    check("hold_ped_count", ped_cnt >= 4, 1);

    // Random enable / button run with invariants
    do_reset();
    pns = 3'b001; pew = 3'b001;
    for (int c = 0; c < 1000; c++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0);
      check("rnd_model", dut_vec(), model_vec());
      check("rnd_safety", !ns_red && !ew_red, 0);
      check("rnd_ns_seq", legal_next(pns, {ns_green, ns_amber, ns_red}), 1);
      check("rnd_ew_seq", legal_next(pew, {ew_green, ew_amber, ew_red}), 1);
      pns = {ns_green, ns_amber, ns_red};
      pew = {ew_green, ew_amber, ew_red};
    end
    // Drain: any outstanding request must be served within one cycle
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 1'b0);
      check("drain_model", dut_vec(), model_vec());
    end
    check("drain_no_wait", ped_wait, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
